// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and memory-arbiter state types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request ports plus the RAM-side bus of the memory arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;
    logic iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
    word_t iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants completed while an instruction fetch waits.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX + 2);
    logic [W-1:0] cnt;
    assign at_max = cnt == W'(MAX);
    always_ff @(posedge CLK)
        if (RST || clr) cnt <= '0;
        else if (inc && !at_max) cnt <= cnt + W'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between instruction and data ports, data first with a starvation guard.
// Define ARB_PERF_EN to build the perf_i/perf_d/perf_stall counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
`ifdef ARB_PERF_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic CLK,
    input  logic RST,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
    , output logic [CNT_W-1:0] perf_i
    , output logic [CNT_W-1:0] perf_d
    , output logic [CNT_W-1:0] perf_stall
`endif
);
    arb_state_t state;
    logic d_req, at_max, i_done, d_done;

    assign d_req  = bus.dREN | bus.dWEN;
    assign i_done = state == IGNT && bus.iREN && bus.ramstate == ACCESS;
    assign d_done = state == DGNT && d_req && bus.ramstate == ACCESS;

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .CLK(CLK),
        .RST(RST),
        .inc(d_done && bus.iREN),
        .clr(i_done),
        .at_max(at_max)
    );

    // A dropped request returns to IDLE without completing; ERROR simply keeps the grant.
    always_ff @(posedge CLK)
        if (RST) state <= IDLE;
        else case (state)
            IDLE:    state <= (bus.iREN && (at_max || !d_req)) ? IGNT : d_req ? DGNT : IDLE;
            IGNT:    state <= (!bus.iREN || i_done) ? IDLE : IGNT;
            DGNT:    state <= (!d_req || d_done) ? IDLE : DGNT;
            default: state <= IDLE;
        endcase

    assign bus.ramREN   = (state == IGNT && bus.iREN) || (state == DGNT && bus.dREN && !bus.dWEN);
    assign bus.ramWEN   = state == DGNT && bus.dWEN;
    assign bus.ramaddr  = state == IGNT ? bus.iaddr : state == DGNT ? bus.daddr : '0;
    assign bus.ramstore = state == DGNT ? bus.dstore : '0;
    assign bus.iwait    = state == IDLE ? bus.iREN : !i_done;
    assign bus.dwait    = state == IDLE ? d_req : !d_done;
    assign bus.iload    = i_done ? bus.ramload : '0;
    assign bus.dload    = d_done ? bus.ramload : '0;

`ifdef ARB_PERF_EN
    always_ff @(posedge CLK)
        if (RST) begin
            perf_i     <= '0;
            perf_d     <= '0;
            perf_stall <= '0;
        end else begin
            perf_i     <= perf_i + CNT_W'(i_done);
            perf_d     <= perf_d + CNT_W'(d_done);
            perf_stall <= perf_stall + CNT_W'(bus.iREN && state != IGNT);
        end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    import cpu_types_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    mem_arbiter_if bus();
`ifdef ARB_PERF_EN
    logic [15:0] perf_i, perf_d, perf_stall;
    logic [15:0] perf_d_before;
    mem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus),
                     .perf_i(perf_i), .perf_d(perf_d), .perf_stall(perf_stall));
`else
    mem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    int exp_kind[6] = '{1, 1, 1, 1, 2, 1};
    int got_kind[6] = '{0, 0, 0, 0, 0, 0};
    int ng = 0;

    initial begin
        bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b1; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
        // 1: reset with both requests high
        RST = 1'b1;
        tick; tick;
        check("rst_ramREN", 32'(bus.ramREN), 0);
        check("rst_ramWEN", 32'(bus.ramWEN), 0);
        check("rst_iwait", 32'(bus.iwait), 1);
        check("rst_dwait", 32'(bus.dwait), 1);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        RST = 1'b0; bus.iREN = 1'b0; bus.dREN = 1'b0;
        tick;
        // 2: instruction fetch, RAM hits on the second grant cycle
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        #1;
        check("t2_req_iwait", 32'(bus.iwait), 1);
        check("t2_req_ramREN", 32'(bus.ramREN), 0);
        tick;
        bus.ramstate = BUSY;
        #1;
        check("t2_g1_ramREN", 32'(bus.ramREN), 1);
        check("t2_g1_ramaddr", bus.ramaddr, 32'h40);
        check("t2_g1_iwait", 32'(bus.iwait), 1);
        check("t2_g1_iload", bus.iload, 0);
        tick;
        bus.ramstate = ACCESS; bus.ramload = 32'h2108000A;
        #1;
        check("t2_g2_iwait", 32'(bus.iwait), 0);
        check("t2_g2_iload", bus.iload, 32'h2108000A);
        tick;
        bus.iREN = 1'b0; bus.ramstate = FREE;
        #1;
        check("t2_idle", 32'(dut.state), 32'(IDLE));
        // 3: simultaneous requests, data write wins, instruction follows
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
        #1;
        check("t3_req_dwait", 32'(bus.dwait), 1);
        tick;
        #1;
        check("t3_ramWEN", 32'(bus.ramWEN), 1);
        check("t3_ramREN", 32'(bus.ramREN), 0);
        check("t3_ramaddr", bus.ramaddr, 32'h80);
        check("t3_ramstore", bus.ramstore, 32'hDEADBEEF);
        check("t3_iwait_d", 32'(bus.iwait), 1);
        bus.ramstate = ACCESS;
        #1;
        check("t3_dwait_done", 32'(bus.dwait), 0);
        tick;
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        #1;
        check("t3_idle_ramREN", 32'(bus.ramREN), 0);
        tick;
        #1;
        check("t3_i_ramREN", 32'(bus.ramREN), 1);
        check("t3_i_ramaddr", bus.ramaddr, 32'h44);
        bus.ramstate = ACCESS; bus.ramload = 32'h12345678;
        #1;
        check("t3_i_iload", bus.iload, 32'h12345678);
        tick;
        bus.iREN = 1'b0; bus.ramstate = FREE;
        // 4: starvation guard with STARVE_MAX=4: D D D D I D
        bus.iREN = 1'b1; bus.iaddr = 32'h48;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (bus.ramREN) begin
                got_kind[ng] = bus.ramaddr == 32'h100 ? 1 : 2;
                ng++;
            end
            tick;
        end
        check("t4_grants", 32'(ng), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t4_grant%0d", i), 32'(got_kind[i]), 32'(exp_kind[i]));
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
        tick;
        // 5: data request withdrawn while granted
`ifdef ARB_PERF_EN
        perf_d_before = perf_d;
`endif
        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = BUSY;
        tick;
        #1;
        check("t5_ramREN", 32'(bus.ramREN), 1);
        check("t5_dwait", 32'(bus.dwait), 1);
        bus.dREN = 1'b0;
        #1;
        check("t5_drop_ramREN", 32'(bus.ramREN), 0);
        check("t5_drop_ramWEN", 32'(bus.ramWEN), 0);
        tick;
        check("t5_idle", 32'(dut.state), 32'(IDLE));
`ifdef ARB_PERF_EN
        check("t5_perf_d", 32'(perf_d), 32'(perf_d_before));
`endif
        // reset in the middle of a write grant abandons it
        bus.dWEN = 1'b1; bus.daddr = 32'h240; bus.ramstate = BUSY;
        tick;
        #1;
        check("t7_ramWEN", 32'(bus.ramWEN), 1);
        RST = 1'b1;
        tick;
        check("t7_state", 32'(dut.state), 32'(IDLE));
        check("t7_ramWEN_rst", 32'(bus.ramWEN), 0);
        RST = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
        tick;
        // 6: ERROR for three grant cycles, then ACCESS
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = ERROR;
        tick;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t6_err%0d_dwait", c), 32'(bus.dwait), 1);
            check($sformatf("t6_err%0d_ramREN", c), 32'(bus.ramREN), 1);
            check($sformatf("t6_err%0d_dload", c), bus.dload, 0);
            tick;
        end
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        #1;
        check("t6_dwait", 32'(bus.dwait), 0);
        check("t6_dload", bus.dload, 32'hCAFEF00D);
        tick;
        bus.dREN = 1'b0; bus.ramstate = FREE;
        #1;
        check("t6_idle", 32'(dut.state), 32'(IDLE));
`ifdef ARB_PERF_EN
        check("t6_perf_d", 32'(perf_d), 1);
        check("t6_perf_i", 32'(perf_i), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
